interrupt_controller: RTL
=========================

Name: interrupt_controller

Overview:
- Arbitrates the three interrupt sources (syscall, scheduler timer, DMA op-complete) into a single vectored request to the CPU fetch/PC unit.
- Latches pending events, picks one by fixed priority at an instruction boundary, and saves the interrupted PC.
- Holds the request until the CPU acknowledges, then blocks nesting until return-from-interrupt.
- Sits between the scheduler / DMA engine and the PC mux.

Parameters:
ADDR_W, 16, width of PC and vector addresses
ACK_TIMEOUT, 16, clock cycles in REQ without int_ack before the request is abandoned (must be >= 2)

Ports:
clock  in  1  system clock, all state on posedge
init_flag  in  1  asynchronous active-low reset
sys_req  in  1  syscall request pulse from decoder
timer_int  in  1  timer interrupt level from scheduler
dma_ready  in  1  DMA operation-complete pulse
sys_int_pos  in  ADDR_W  syscall vector
timer_int_pos  in  ADDR_W  timer vector
op_int_pos  in  ADDR_W  DMA vector
int_mask  in  2  mask bits: [0] timer, [1] DMA (1 = masked); syscall is never masked
kernel_mode  in  1  1 = CPU in kernel mode; timer and DMA are not dispatched
PRG_ENB  in  1  instruction boundary strobe
PC_pos  in  ADDR_W  PC of the next instruction
int_ack  in  1  CPU has taken the jump
int_ret  in  1  return-from-interrupt executed
int_req  out  1  interrupt request to the PC unit
int_pos  out  ADDR_W  jump vector, valid while int_req = 1
int_src  out  2  source: 01 syscall, 10 timer, 11 DMA, 00 none
saved_PC  out  ADDR_W  PC captured at dispatch
pending  out  3  pending bits {dma, timer, sys}
busy  out  1  1 in REQ or SERVICE
ack_err  out  1  sticky timeout flag

Behaviour:
- Reset (init_flag = 0, asynchronous): state = IDLE. All outputs = 0, including pending, saved_PC, ack_err, and the timer-edge register.
- Pending capture, every cycle in every state:
  - sys pending bit is set by sys_req = 1.
  - dma pending bit is set by dma_ready = 1.
  - timer pending bit is set only on a 0->1 edge of timer_int (registered previous value).
  - A set and a clear of the same bit in the same cycle: set wins.
- Eligible source: sys pending, OR (timer pending AND !int_mask[0] AND !kernel_mode), OR (dma pending AND !int_mask[1] AND !kernel_mode).
- Priority: sys > timer > dma.
- State IDLE:
  - When PRG_ENB = 1 and any source is eligible, on the next edge: saved_PC <= PC_pos; int_pos <= that source's vector; int_src <= its code; int_req <= 1; busy <= 1; go to REQ.
  - Latency: request visible one cycle after the qualifying PRG_ENB.
- State REQ:
  - int_req, int_pos and int_src are held stable. Vector inputs changing during REQ have no effect.
  - A wait counter increments each cycle.
  - On int_ack = 1: clear the selected pending bit; int_req <= 0; reset the counter; go to SERVICE. int_src is held.
  - If the counter reaches ACK_TIMEOUT-1 without int_ack: int_req <= 0; int_src <= 00; ack_err <= 1; go to IDLE. The pending bit is kept, so the source is retried at a later boundary.
  - int_ack and timeout in the same cycle: ack wins.
- State SERVICE:
  - No dispatch (no nesting). Pending bits still accumulate.
  - On int_ret = 1: int_src <= 00; busy <= 0; go to IDLE.
  - Re-dispatch is possible at the first PRG_ENB after returning to IDLE.
- int_ack outside REQ and int_ret outside SERVICE are ignored.
- ack_err clears only on reset.
- saved_PC holds its value until the next dispatch.

Test Plan:
- Reset, then sys_req pulse with sys_int_pos=0x0040, PC_pos=0x0123, PRG_ENB=1 -> int_req=1 next cycle, int_pos=0x0040, int_src=01, saved_PC=0x0123. int_ack -> pending[0]=0, SERVICE. int_ret -> busy=0.
- sys_req, dma_ready and a timer_int rise in the same cycle, kernel_mode=0, no masks -> dispatch order sys, timer, dma across three ack/ret cycles, with vectors matching each source.
- kernel_mode=1 with timer and DMA pending -> no int_req for 20 boundaries. Drop kernel_mode -> timer dispatched first. int_mask=10 with DMA pending -> DMA is never dispatched.
- Dispatch with no int_ack, ACK_TIMEOUT=16 -> int_req falls after 16 cycles in REQ, ack_err=1, pending bit retained, re-dispatch at the next PRG_ENB.
- timer_int held high for 100 cycles -> exactly one timer dispatch. dma_ready pulse during SERVICE -> pending[2]=1, dispatched only after int_ret.
- Assert init_flag=0 mid-REQ -> int_req, busy, pending and ack_err go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_controller
// Purpose  : Fixed-priority (sys > timer > dma) vectored interrupt arbiter with
//            PC capture, acknowledge timeout and no nesting until return.
// Revision : 1.0
// ============================================================================
module interrupt_controller #(
  parameter int ADDR_W      = 16,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              init_flag,
  input  logic              sys_req,
  input  logic              timer_int,
  input  logic              dma_ready,
  input  logic [ADDR_W-1:0] sys_int_pos,
  input  logic [ADDR_W-1:0] timer_int_pos,
  input  logic [ADDR_W-1:0] op_int_pos,
  input  logic [1:0]        int_mask,
  input  logic              kernel_mode,
  input  logic              PRG_ENB,
  input  logic [ADDR_W-1:0] PC_pos,
  input  logic              int_ack,
  input  logic              int_ret,
  output logic              int_req,
  output logic [ADDR_W-1:0] int_pos,
  output logic [1:0]        int_src,
  output logic [ADDR_W-1:0] saved_PC,
  output logic [2:0]        pending,
  output logic              busy,
  output logic              ack_err
);

  localparam int               CNT_W      = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [1:0]       c_SRC_NONE = 2'b00;
  localparam logic [1:0]       c_SRC_SYS  = 2'b01;
  localparam logic [1:0]       c_SRC_TMR  = 2'b10;
  localparam logic [1:0]       c_SRC_DMA  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_timer_q;
  logic [2:0]        r_pending;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_int_req;
  logic [ADDR_W-1:0] r_int_pos;
  logic [1:0]        r_int_src;
  logic [ADDR_W-1:0] r_saved_pc;
  logic              r_busy;
  logic              r_ack_err;

  logic              w_tmr_ok;
  logic              w_dma_ok;
  logic [1:0]        w_sel_src;
  logic [ADDR_W-1:0] w_sel_vec;
  logic              w_any;
  logic              w_dispatch;
  logic              w_ack;
  logic              w_timeout;
  logic              w_ret;
  logic [2:0]        w_set;
  logic [2:0]        w_clr;

  assign w_tmr_ok = r_pending[1] & ~int_mask[0] & ~kernel_mode;
  assign w_dma_ok = r_pending[2] & ~int_mask[1] & ~kernel_mode;
  assign w_any    = (w_sel_src != c_SRC_NONE);

  // Timer is edge-captured so a level held high requests only once.
  assign w_set = {dma_ready, timer_int & ~r_timer_q, sys_req};
  assign w_clr = {3{w_ack}} & {r_int_src == c_SRC_DMA,
                               r_int_src == c_SRC_TMR,
                               r_int_src == c_SRC_SYS};

  always_comb begin
    w_sel_src = c_SRC_NONE;
    w_sel_vec = sys_int_pos;
    if (r_pending[0]) begin
      w_sel_src = c_SRC_SYS;
      w_sel_vec = sys_int_pos;
    end else if (w_tmr_ok) begin
      w_sel_src = c_SRC_TMR;
      w_sel_vec = timer_int_pos;
    end else if (w_dma_ok) begin
      w_sel_src = c_SRC_DMA;
      w_sel_vec = op_int_pos;
    end
  end

  always_ff @(posedge clock or negedge init_flag) begin
    if (!init_flag) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dispatch  = 1'b0;
    w_ack       = 1'b0;
    w_timeout   = 1'b0;
    w_ret       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (PRG_ENB && w_any) begin
          w_dispatch  = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // Acknowledge takes precedence over a coincident timeout.
        if (int_ack) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_SERVICE;
        end else if (r_cnt == c_CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (int_ret) begin
          w_ret       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge init_flag) begin
    if (!init_flag) begin
      r_timer_q  <= 1'b0;
      r_pending  <= 3'b000;
      r_cnt      <= '0;
      r_int_req  <= 1'b0;
      r_int_pos  <= '0;
      r_int_src  <= c_SRC_NONE;
      r_saved_pc <= '0;
      r_busy     <= 1'b0;
      r_ack_err  <= 1'b0;
    end else begin
      r_timer_q <= timer_int;
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_dispatch) begin
        r_saved_pc <= PC_pos;
        r_int_pos  <= w_sel_vec;
        r_int_src  <= w_sel_src;
        r_int_req  <= 1'b1;
        r_busy     <= 1'b1;
        r_cnt      <= '0;
      end else if (w_ack) begin
        r_int_req <= 1'b0;
        r_cnt     <= '0;
      end else if (w_timeout) begin
        r_int_req <= 1'b0;
        r_int_src <= c_SRC_NONE;
        r_ack_err <= 1'b1;
        r_busy    <= 1'b0;
        r_cnt     <= '0;
      end else if (w_ret) begin
        r_int_src <= c_SRC_NONE;
        r_busy    <= 1'b0;
      end else if (r_state == ST_REQ) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign int_req  = r_int_req;
  assign int_pos  = r_int_pos;
  assign int_src  = r_int_src;
  assign saved_PC = r_saved_pc;
  assign pending  = r_pending;
  assign busy     = r_busy;
  assign ack_err  = r_ack_err;

endmodule
`default_nettype wire
